poly_cmd_writer: RTL

Host-side producer for the polynomial evaluation accelerator's input interface. It accepts one instruction at a time from the host (opcode, slot, argument), streams that instruction's data tokens into the input data FIFO, and then pushes the packed 16-bit command word into the input command FIFO. Data always precedes its command, so the firing-state controller never sees a command whose operands are missing. It sits between the host/testbench stimulus port and the two input FIFOs that feed the accelerator's memory controllers.

---
 rtl/poly_cmd_writer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/poly_cmd_writer.sv
// rtl/poly_cmd_writer.sv - host instruction writer: data tokens then packed command word into input FIFOs
// Optional build macro: POLY_CMD_ARGCHECK_EN (reject opcodes above 3 and EVB with b=0)
module poly_cmd_writer #(
  parameter int word_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [7:0]           cmd_instr,
  input  logic [2:0]           cmd_arg1,
  input  logic [4:0]           cmd_arg2,
  output logic                 cmd_ready,
  input  logic                 data_valid,
  input  logic [word_size-1:0] data_in,
  output logic                 data_ready,
  input  logic [word_size-1:0] free_fifo_data,
  input  logic [word_size-1:0] free_fifo_command,
  output logic                 wr_en_fifo_data,
  output logic [word_size-1:0] data_out,
  output logic                 wr_en_fifo_command,
  output logic [word_size-1:0] command_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, DATA, CMD, ERROR} state_t;

  state_t               state, state_nxt;
  logic [word_size-1:0] cmd_word;
  logic [5:0]           remaining;
  logic [5:0]           count;
  logic                 illegal;

  // Token count and legality of the instruction currently offered by the host
  always_comb begin
    count   = 6'd0;
    illegal = 1'b0;
    case (cmd_instr)
      8'd0:    count = {1'b0, cmd_arg2} + 6'd1;
      8'd1:    count = 6'd1;
      8'd2:    count = {1'b0, cmd_arg2};
      default: count = 6'd0;
    endcase
`ifdef POLY_CMD_ARGCHECK_EN
    illegal = (cmd_instr > 8'd3) || ((cmd_instr == 8'd2) && (cmd_arg2 == 5'd0));
`else
    illegal = 1'b0;
`endif
  end

  // Next-state and handshake/strobe outputs; everything held inactive while rst is high
  always_comb begin
    state_nxt          = state;
    cmd_ready          = 1'b0;
    data_ready         = 1'b0;
    wr_en_fifo_data    = 1'b0;
    wr_en_fifo_command = 1'b0;
    done               = 1'b0;
    err                = 1'b0;
    busy               = (state != IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (illegal)            state_nxt = ERROR;
          else if (count == 6'd0) state_nxt = CMD;
          else                    state_nxt = DATA;
        end
      end
      DATA: begin
        data_ready      = (free_fifo_data != '0);
        wr_en_fifo_data = data_valid && data_ready;
        if (wr_en_fifo_data && (remaining == 6'd1)) state_nxt = CMD;
      end
      CMD: begin
        wr_en_fifo_command = (free_fifo_command != '0);
        done               = wr_en_fifo_command;
        if (wr_en_fifo_command) state_nxt = IDLE;
      end
      ERROR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt          = IDLE;
      cmd_ready          = 1'b0;
      data_ready         = 1'b0;
      wr_en_fifo_data    = 1'b0;
      wr_en_fifo_command = 1'b0;
      done               = 1'b0;
      err                = 1'b0;
      busy               = 1'b0;
    end
  end

  // Data tokens pass straight through; the command word is the latched instruction
  always_comb begin
    data_out    = data_in;
    command_out = rst ? '0 : cmd_word;
  end

  // State, latched command word and remaining-token counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_word  <= '0;
      remaining <= 6'd0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && cmd_valid) begin
        cmd_word  <= {cmd_instr, cmd_arg1, cmd_arg2};
        remaining <= count;
      end else if (wr_en_fifo_data) begin
        remaining <= remaining - 6'd1;
      end
    end
  end

endmodule
